// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one SEG-bit segment
// and hands its carry, the finished low sum bits and the untouched high operand bits onward.
module cla_pipe_adder #(
    parameter int WIDTH  = 44,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_sub,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_ovf
);
    localparam int SEG = WIDTH / STAGES;

    // Handshake: a beat is accepted when i_valid && o_ready, a result is consumed when
    // o_valid && i_ready. All stages move together on adv; empty slots advance like data.
    logic             adv;
    logic [WIDTH-1:0] b_cond;
    logic             c0;
    logic [WIDTH:0]   result_d;
    logic             ovf_d;
    logic             valid_d;
    logic [WIDTH:0]   result_q;
    logic             ovf_q;
    logic             valid_q;

    assign adv     = !valid_q || i_ready;
    assign o_ready = adv;
    assign b_cond  = i_sub ? ~i_add2 : i_add2;
    assign c0      = i_sub ? ~i_cin : i_cin;

    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                             input logic cin);
        logic [SEG:0]   c;
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG-1:0] s;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            g[i]     = a[i] & b[i];
            p[i]     = a[i] | b[i];
            c[i+1]   = g[i] | (p[i] & c[i]);
            s[i]     = a[i] ^ b[i] ^ c[i];
        end
        return {c[SEG], s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic                cin_in;
        logic                vld_in;
        logic [SEG:0]        seg_res;
        logic [LO+SEG-1:0]   sum_acc;

        if (k == 0) begin : g_src
            assign a_in    = i_add1;
            assign b_in    = b_cond;
            assign cin_in  = c0;
            assign vld_in  = i_valid;
            assign sum_acc = seg_res[SEG-1:0];
        end else begin : g_src
            assign a_in    = g_stage[k-1].g_reg.a_q;
            assign b_in    = g_stage[k-1].g_reg.b_q;
            assign cin_in  = g_stage[k-1].g_reg.c_q;
            assign vld_in  = g_stage[k-1].g_reg.v_q;
            assign sum_acc = {seg_res[SEG-1:0], g_stage[k-1].g_reg.sum_q};
        end

        assign seg_res = cla_seg(a_in[SEG-1:0], b_in[SEG-1:0], cin_in);

        if (k < STAGES - 1) begin : g_reg
            localparam int HI = WIDTH - LO - SEG;
            logic [HI-1:0]     a_q;
            logic [HI-1:0]     b_q;
            logic [LO+SEG-1:0] sum_q;
            logic              c_q;
            logic              v_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                    c_q   <= 1'b0;
                    v_q   <= 1'b0;
                end else if (adv) begin
                    a_q   <= a_in[WIDTH-LO-1:SEG];
                    b_q   <= b_in[WIDTH-LO-1:SEG];
                    sum_q <= sum_acc;
                    c_q   <= seg_res[SEG];
                    v_q   <= vld_in;
                end
            end
        end else begin : g_out
            // Top segment holds the sign bits, so overflow is decided here.
            assign result_d = {seg_res[SEG], sum_acc};
            assign ovf_d    = (a_in[WIDTH-LO-1] == b_in[WIDTH-LO-1]) &&
                              (seg_res[SEG-1] != a_in[WIDTH-LO-1]);
            assign valid_d  = vld_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else if (adv) begin
            result_q <= result_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign o_result = result_q;
    assign o_ovf    = ovf_q;
    assign o_valid  = valid_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed vectors on a 44/4 instance plus
// randomised valid/ready streams on 8/1, 16/2, 44/4 and 64/8 instances.
module tb_cla_pipe_adder;
    localparam int W = 44;
    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         sw_rst_n;
    logic         i_valid;
    logic         i_ready;
    logic         i_sub;
    logic         i_cin;
    logic [W-1:0] i_add1;
    logic [W-1:0] i_add2;
    logic         o_ready;
    logic         o_valid;
    logic         o_ovf;
    logic [W:0]   o_result;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cons   = 0;
    logic [W+1:0] exp_q[$];

    cla_pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_add1  (i_add1),
        .i_add2  (i_add2),
        .i_sub   (i_sub),
        .i_cin   (i_cin),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_result(o_result),
        .o_ovf   (o_ovf)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic c);
        logic [W-1:0] bp;
        logic [W:0]   sum;
        logic         cc;
        bp  = s ? ~b : b;
        cc  = s ? ~c : c;
        sum = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, cc};
        return {(a[W-1] == bp[W-1]) && (sum[W-1] != a[W-1]), sum};
    endfunction

    function automatic logic [W-1:0] rnd_w();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input logic [W+1:0] exp,
                        input logic r, output logic acc);
        logic [W+1:0] e;
        @(negedge clk);
        i_valid = v;
        i_add1  = a;
        i_add2  = b;
        i_sub   = s;
        i_cin   = c;
        i_ready = r;
        #1;
        if (o_valid && i_ready) begin
            n_cons++;
            check("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", o_result, e[W:0]);
                check("ovf", o_ovf, e[W+1]);
            end
        end
        acc = v && o_ready;
        if (acc) exp_q.push_back(exp);
    endtask

    function automatic int sw_w(input int i);
        case (i)
            0:       return 8;
            1:       return 16;
            2:       return 44;
            default: return 64;
        endcase
    endfunction

    function automatic int sw_s(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int SW = sw_w(g);
        localparam int SS = sw_s(g);
        logic          v_i;
        logic          rdy_o;
        logic          v_o;
        logic          r_i;
        logic          s_i;
        logic          c_i;
        logic          ovf_o;
        logic [SW-1:0] a_i;
        logic [SW-1:0] b_i;
        logic [SW:0]   res_o;
        logic [SW+1:0] q[$];
        logic          done = 1'b0;

        cla_pipe_adder #(.WIDTH(SW), .STAGES(SS)) u_dut (
            .i_clk   (clk),
            .i_rst_n (sw_rst_n),
            .i_valid (v_i),
            .o_ready (rdy_o),
            .i_add1  (a_i),
            .i_add2  (b_i),
            .i_sub   (s_i),
            .i_cin   (c_i),
            .o_valid (v_o),
            .i_ready (r_i),
            .o_result(res_o),
            .o_ovf   (ovf_o)
        );

        function automatic logic [SW+1:0] sw_model(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                                   input logic s, input logic c);
            logic [SW-1:0] bp;
            logic [SW:0]   sum;
            logic          cc;
            bp  = s ? ~b : b;
            cc  = s ? ~c : c;
            sum = {1'b0, a} + {1'b0, bp} + {{SW{1'b0}}, cc};
            return {(a[SW-1] == bp[SW-1]) && (sum[SW-1] != a[SW-1]), sum};
        endfunction

        function automatic logic [SW-1:0] sw_rnd();
            case ($urandom_range(0, 7))
                0:       return '0;
                1:       return '1;
                default: return SW'({$urandom(), $urandom()});
            endcase
        endfunction

        task automatic sw_step(input logic v, input logic r, output logic acc);
            logic [SW+1:0] e;
            @(negedge clk);
            v_i = v;
            r_i = r;
            a_i = sw_rnd();
            b_i = sw_rnd();
            s_i = 1'($urandom_range(0, 1));
            c_i = 1'($urandom_range(0, 1));
            #1;
            if (v_o && r_i) begin
                check($sformatf("sw%0d_nonempty", SW), q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check($sformatf("sw%0d_result", SW), res_o, e[SW:0]);
                    check($sformatf("sw%0d_ovf", SW), ovf_o, e[SW+1]);
                end
            end
            acc = v_i && rdy_o;
            if (acc) q.push_back(sw_model(a_i, b_i, s_i, c_i));
        endtask

        initial begin : sw_run
            logic acc;
            int   lat;
            int   n_acc;
            v_i = 1'b0;
            r_i = 1'b1;
            a_i = '0;
            b_i = '0;
            s_i = 1'b0;
            c_i = 1'b0;
            wait (sw_rst_n === 1'b1);
            sw_step(1'b1, 1'b1, acc);
            check($sformatf("sw%0d_lat_acc", SW), acc, 1);
            lat = 0;
            sw_step(1'b0, 1'b1, acc);
            while (!v_o && lat < 20) begin
                sw_step(1'b0, 1'b1, acc);
                lat++;
            end
            check($sformatf("sw%0d_latency", SW), lat, SS - 1);
            n_acc = 0;
            for (int t = 0; t < 40000 && n_acc < 10000; t++) begin
                sw_step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
                if (acc) n_acc++;
            end
            check($sformatf("sw%0d_beats", SW), n_acc, 10000);
            for (int t = 0; t < 40 && q.size() > 0; t++) sw_step(1'b0, 1'b1, acc);
            check($sformatf("sw%0d_drain", SW), q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin : main
        logic         acc;
        logic         first;
        logic         rdy;
        int           lat;
        int           bi;
        int           hold;
        int           cons0;
        logic [W:0]   snap;
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        logic         cs;
        logic         cc;

        rst_n    = 1'b0;
        sw_rst_n = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_sub    = 1'b0;
        i_cin    = 1'b0;
        i_add1   = '0;
        i_add2   = '0;
        snap     = '0;
        #12;
        check("rst_valid", o_valid, 0);
        check("rst_result", o_result, 0);
        check("rst_ovf", o_ovf, 0);
        check("rst_ready", o_ready, 1);
        @(negedge clk);
        #2;
        rst_n    = 1'b1;
        sw_rst_n = 1'b1;

        // Carry ripples through all four segments; also measures latency.
        step(1'b1, 44'hFFF_FFFF_FFFF, 44'h1, 1'b0, 1'b0, {1'b0, 45'h1000_0000_0000}, 1'b1, acc);
        check("carry_acc", acc, 1);
        lat = 0;
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, acc);
        while (!o_valid && lat < 20) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, acc);
            lat++;
        end
        check("latency", lat, S - 1);

        step(1'b1, 44'h5, 44'h7, 1'b1, 1'b0, {1'b0, 45'h0FFF_FFFF_FFFE}, 1'b1, acc);
        step(1'b1, 44'h5, 44'h7, 1'b1, 1'b1, {1'b0, 45'h0FFF_FFFF_FFFD}, 1'b1, acc);
        step(1'b1, 44'h7FF_FFFF_FFFF, 44'h1, 1'b0, 1'b0, {1'b1, 45'h0800_0000_0000}, 1'b1, acc);
        step(1'b1, 44'h800_0000_0000, 44'h1, 1'b1, 1'b0, {1'b1, 45'h17FF_FFFF_FFFF}, 1'b1, acc);
        for (int t = 0; t < 8; t++) step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, acc);
        check("directed_drain", exp_q.size(), 0);

        cons0 = n_cons;
        bi    = 0;
        hold  = 0;
        first = 1'b0;
        ca    = rnd_w();
        cb    = rnd_w();
        cs    = 1'($urandom_range(0, 1));
        cc    = 1'($urandom_range(0, 1));
        for (int st = 0; st < 80 && (bi < 8 || exp_q.size() > 0); st++) begin
            rdy = !(first && hold < 5);
            step(bi < 8, ca, cb, cs, cc, model(ca, cb, cs, cc), rdy, acc);
            if (!rdy) begin
                check("bp_ready", o_ready, 0);
                check("bp_valid", o_valid, 1);
                if (hold == 0) snap = o_result;
                else check("bp_stable", o_result, snap);
                hold++;
            end
            if (o_valid) first = 1'b1;
            if (acc) begin
                bi++;
                ca = rnd_w();
                cb = rnd_w();
                cs = 1'($urandom_range(0, 1));
                cc = 1'($urandom_range(0, 1));
            end
        end
        check("bp_hold_cycles", hold, 5);
        check("bp_count", n_cons - cons0, 8);
        check("bp_drain", exp_q.size(), 0);

        for (int k = 0; k < 4; k++) begin
            ca = rnd_w();
            cb = rnd_w();
            step(1'b1, ca, cb, 1'b0, 1'b1, model(ca, cb, 1'b0, 1'b1), 1'b1, acc);
        end
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        check("rst_mid_pre_valid", o_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", o_valid, 0);
        check("rst_mid_result", o_result, 0);
        check("rst_mid_ovf", o_ovf, 0);
        check("rst_mid_ready", o_ready, 1);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, acc);
            check("rst_stale", o_valid, 0);
        end

        for (int t = 0; t < 50000 &&
             !(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done); t++)
            @(negedge clk);
        check("sweep_done", {g_sw[3].done, g_sw[2].done, g_sw[1].done, g_sw[0].done}, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
